// File: rtl/wb_pkg.sv
// Shared types for the Ibex-to-Wishbone host bridge.
//   bridge_state_e : bridge FSM state encoding (IDLE, REQ, WAIT)
//   cnt_width()    : width of a saturating counter that must reach a given count
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } bridge_state_e;

  // Width that holds 0..n inclusive; never less than one bit so a
  // disabled counter (n == 0) still has a legal declaration.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating cycle counter used to detect a hung Wishbone slave.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : clear to zero (wins over en_i)
//   en_i         : count up by one, saturating at all-ones
//   expired_o    : count equals MaxCount-1; constant 0 when MaxCount == 0
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int unsigned MaxCount = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = cnt_width(MaxCount);

  generate
    if (MaxCount == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam logic [CntW-1:0] Limit = CntW'(MaxCount - 1);
      logic [CntW-1:0] r_count;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_count <= '0;
        end else if (clr_i) begin
          r_count <= '0;
        end else if (en_i && (r_count != {CntW{1'b1}})) begin
          r_count <= r_count + CntW'(1);
        end
      end

      assign expired_o = (r_count == Limit);
    end
  endgenerate

endmodule

// File: rtl/ibex_wb_host_bridge.sv
// Bridges one Ibex-style host port (req/gnt/rvalid) onto a pipelined
// Wishbone master port. One transaction outstanding at a time; cyc is held
// for the whole bus cycle and a timeout turns a silent slave into an error.
//   host_*_i/o : Ibex request/grant and one-cycle rvalid response
//   wb_*_o     : registered Wishbone master outputs (cyc/stb/we/addr/data/sel)
//   wb_*_i     : slave stall/ack/err and read data
module ibex_wb_host_bridge
  import wb_pkg::*;
#(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      host_req_i,
  output logic                      host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i,
  input  logic                      host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i,
  input  logic [DataWidth-1:0]      host_wdata_i,
  output logic                      host_rvalid_o,
  output logic [DataWidth-1:0]      host_rdata_o,
  output logic                      host_err_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [AddressWidth-1:0]   wb_addr_o,
  output logic [DataWidth-1:0]      wb_data_o,
  output logic [DataWidth/8-1:0]    wb_sel_o,
  input  logic                      wb_stall_i,
  input  logic                      wb_ack_i,
  input  logic [DataWidth-1:0]      wb_data_i,
  input  logic                      wb_err_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  bridge_state_e             r_state;
  logic                      r_cyc;
  logic                      r_stb;
  logic                      r_we;
  logic [AddressWidth-1:0]   r_addr;
  logic [DataWidth-1:0]      r_wdata;
  logic [BeWidth-1:0]        r_sel;
  logic                      r_rvalid;
  logic [DataWidth-1:0]      r_rdata;
  logic                      r_err;

  logic w_grant;
  logic w_expired;
  logic w_cnt_en;

  // Grant is combinational so a request can be taken in the same cycle the
  // previous response pulses (that cycle is always spent in IDLE).
  assign w_grant  = (r_state == IDLE) && host_req_i;
  assign w_cnt_en = (r_state == REQ) || (r_state == WAIT);

  // Cleared on the grant edge, so it reads 0 in the first strobe cycle.
  wb_timeout_cnt #(
    .MaxCount (TimeoutCycles)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_grant),
    .en_i      (w_cnt_en),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sel    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_addr  <= host_addr_i;
            r_we    <= host_we_i;
            r_sel   <= host_be_i;
            r_wdata <= host_wdata_i;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          // ack/err here cannot belong to this strobe and are ignored.
          if (w_expired) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_state  <= IDLE;
          end else if (!wb_stall_i) begin
            r_stb   <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // A real slave response beats a timeout landing in the same cycle;
          // err beats ack.
          if (wb_err_i) begin
            r_cyc    <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_state  <= IDLE;
          end else if (wb_ack_i) begin
            r_cyc    <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b0;
            r_rdata  <= wb_data_i;
            r_state  <= IDLE;
          end else if (w_expired) begin
            r_cyc    <= 1'b0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign host_gnt_o    = w_grant;
  assign host_rvalid_o = r_rvalid;
  assign host_rdata_o  = r_rdata;
  assign host_err_o    = r_err;
  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_stb;
  assign wb_we_o       = r_we;
  assign wb_addr_o     = r_addr;
  assign wb_data_o     = r_wdata;
  assign wb_sel_o      = r_sel;

endmodule

// File: tb/tb_ibex_wb_host_bridge.sv
// Directed bench for ibex_wb_host_bridge (TimeoutCycles = 8).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_ibex_wb_host_bridge;

  logic        clk;
  logic        rst;
  logic        host_req;
  logic        host_gnt;
  logic [31:0] host_addr;
  logic        host_we;
  logic [3:0]  host_be;
  logic [31:0] host_wdata;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        host_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_stall;
  logic        wb_ack;
  logic [31:0] wb_rdata;
  logic        wb_err;

  int n_pass  = 0;
  int n_total = 0;

  ibex_wb_host_bridge #(
    .DataWidth     (32),
    .AddressWidth  (32),
    .TimeoutCycles (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host_req_i    (host_req),
    .host_gnt_o    (host_gnt),
    .host_addr_i   (host_addr),
    .host_we_i     (host_we),
    .host_be_i     (host_be),
    .host_wdata_i  (host_wdata),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .host_err_o    (host_err),
    .wb_cyc_o      (wb_cyc),
    .wb_stb_o      (wb_stb),
    .wb_we_o       (wb_we),
    .wb_addr_o     (wb_addr),
    .wb_data_o     (wb_wdata),
    .wb_sel_o      (wb_sel),
    .wb_stall_i    (wb_stall),
    .wb_ack_i      (wb_ack),
    .wb_data_i     (wb_rdata),
    .wb_err_i      (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to the next falling edge; caller then sets inputs and calls settle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    b2b_addr[0] = 32'h0000_0100; b2b_data[0] = 32'h1111_0001;
    b2b_addr[1] = 32'h0000_0104; b2b_data[1] = 32'h2222_0002;
    b2b_addr[2] = 32'h0000_0108; b2b_data[2] = 32'h3333_0003;

    rst = 1'b1; host_req = 1'b0; host_addr = '0; host_we = 1'b0;
    host_be = '0; host_wdata = '0; wb_stall = 1'b0; wb_ack = 1'b0;
    wb_rdata = '0; wb_err = 1'b0;

    // ---------------- reset state
    next_cycle(); next_cycle(); settle();
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_err", host_err, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_gnt", host_gnt, 0);
    next_cycle(); rst = 1'b0;
    $display("reset released");

    // ---------------- 1: single read, zero wait states
    next_cycle(); host_req = 1'b1; host_addr = 32'h8000_1004; host_we = 1'b0; host_be = 4'hF; settle();
    chk("t1_gnt", host_gnt, 1);
    chk("t1_cyc_N", wb_cyc, 0);
    next_cycle(); host_req = 1'b0; settle();
    chk("t1_stb_N1", wb_stb, 1);
    chk("t1_cyc_N1", wb_cyc, 1);
    chk("t1_addr", wb_addr, 32'h8000_1004);
    chk("t1_we", wb_we, 0);
    chk("t1_gnt_busy", host_gnt, 0);
    next_cycle(); wb_ack = 1'b1; wb_rdata = 32'hDEAD_BEEF; settle();
    chk("t1_stb_N2", wb_stb, 0);
    chk("t1_cyc_N2", wb_cyc, 1);
    chk("t1_rvalid_N2", host_rvalid, 0);
    next_cycle(); wb_ack = 1'b0; wb_rdata = '0; settle();
    chk("t1_rvalid_N3", host_rvalid, 1);
    chk("t1_rdata", host_rdata, 32'hDEAD_BEEF);
    chk("t1_err", host_err, 0);
    chk("t1_cyc_N3", wb_cyc, 0);
    next_cycle(); settle();
    chk("t1_rvalid_N4", host_rvalid, 0);
    chk("t1_rdata_hold", host_rdata, 32'hDEAD_BEEF);
    $display("txn 1 single read done");

    // ---------------- 2: write with 3 stall cycles (stray ack during stall ignored)
    next_cycle(); host_req = 1'b1; host_we = 1'b1; host_addr = 32'h0010_0000;
    host_be = 4'h3; host_wdata = 32'h0000_1234; wb_stall = 1'b1; settle();
    chk("t2_gnt", host_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); host_req = 1'b0; host_addr = '0; host_be = '0; host_wdata = '0;
      wb_ack = (i == 1); settle();
      chk("t2_stb_stall", wb_stb, 1);
      chk("t2_addr_stable", wb_addr, 32'h0010_0000);
      chk("t2_sel_stable", wb_sel, 4'h3);
      chk("t2_data_stable", wb_wdata, 32'h0000_1234);
      chk("t2_rvalid_stall", host_rvalid, 0);
    end
    next_cycle(); wb_ack = 1'b0; wb_stall = 1'b0; settle();
    chk("t2_stb_4th", wb_stb, 1);
    chk("t2_we", wb_we, 1);
    next_cycle(); settle();
    chk("t2_stb_wait", wb_stb, 0);
    chk("t2_cyc_wait", wb_cyc, 1);
    next_cycle(); wb_ack = 1'b1; wb_rdata = 32'h0000_5555; settle();
    chk("t2_cyc_at_ack", wb_cyc, 1);
    next_cycle(); wb_ack = 1'b0; wb_rdata = '0; settle();
    chk("t2_rvalid", host_rvalid, 1);
    chk("t2_err", host_err, 0);
    chk("t2_rdata", host_rdata, 32'h0000_5555);
    chk("t2_cyc_drop", wb_cyc, 0);
    next_cycle(); settle();
    chk("t2_rvalid_once", host_rvalid, 0);
    $display("txn 2 stalled write done");

    // ---------------- 3: ack and err together -> error response
    next_cycle(); host_req = 1'b1; host_we = 1'b0; host_addr = 32'h0000_0040; host_be = 4'hF; settle();
    chk("t3_gnt", host_gnt, 1);
    next_cycle(); host_req = 1'b0; settle();
    chk("t3_stb", wb_stb, 1);
    next_cycle(); wb_ack = 1'b1; wb_err = 1'b1; wb_rdata = 32'hFFFF_FFFF; settle();
    chk("t3_cyc", wb_cyc, 1);
    next_cycle(); wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0; settle();
    chk("t3_rvalid", host_rvalid, 1);
    chk("t3_err", host_err, 1);
    chk("t3_rdata", host_rdata, 0);
    $display("txn 3 slave error done");

    // ---------------- 4: timeout after 8 cycles of cyc
    next_cycle(); host_req = 1'b1; host_addr = 32'h0000_0080; settle();
    chk("t4_gnt", host_gnt, 1);
    next_cycle(); host_req = 1'b0; settle();
    chk("t4_stb_rise", wb_stb, 1);
    for (int i = 0; i < 7; i++) begin
      next_cycle(); settle();
      chk("t4_cyc_held", wb_cyc, 1);
      chk("t4_no_rvalid", host_rvalid, 0);
    end
    next_cycle(); host_req = 1'b1; host_addr = 32'h0000_0084; settle();
    chk("t4_cyc_drop", wb_cyc, 0);
    chk("t4_stb_drop", wb_stb, 0);
    chk("t4_rvalid", host_rvalid, 1);
    chk("t4_err", host_err, 1);
    chk("t4_rdata", host_rdata, 0);
    chk("t4_new_gnt", host_gnt, 1);
    next_cycle(); host_req = 1'b0; settle();
    chk("t4_rvalid_once", host_rvalid, 0);
    chk("t4_new_stb", wb_stb, 1);
    chk("t4_new_addr", wb_addr, 32'h0000_0084);
    next_cycle(); wb_ack = 1'b1; wb_rdata = 32'hA5A5_A5A5; settle();
    next_cycle(); wb_ack = 1'b0; wb_rdata = '0; settle();
    chk("t4_after_rvalid", host_rvalid, 1);
    chk("t4_after_err", host_err, 0);
    chk("t4_after_rdata", host_rdata, 32'hA5A5_A5A5);
    $display("txn 4 timeout done");

    // ---------------- 5: back-to-back reads with req held
    for (int i = 0; i < 3; i++) begin
      next_cycle(); wb_ack = 1'b0; wb_rdata = '0; host_req = 1'b1; host_addr = b2b_addr[i]; settle();
      chk("t5_gnt", host_gnt, 1);
      if (i > 0) begin
        chk("t5_rvalid_at_gnt", host_rvalid, 1);
        chk("t5_rdata_at_gnt", host_rdata, b2b_data[i-1]);
      end
      next_cycle(); settle();
      chk("t5_gnt_busy", host_gnt, 0);
      chk("t5_stb", wb_stb, 1);
      chk("t5_addr", wb_addr, b2b_addr[i]);
      next_cycle(); wb_ack = 1'b1; wb_rdata = b2b_data[i]; settle();
      chk("t5_gnt_wait", host_gnt, 0);
    end
    next_cycle(); wb_ack = 1'b0; wb_rdata = '0; host_req = 1'b0; settle();
    chk("t5_last_rvalid", host_rvalid, 1);
    chk("t5_last_rdata", host_rdata, b2b_data[2]);
    $display("txn 5 back-to-back done");

    // ---------------- 6: reset while waiting for ack
    next_cycle(); host_req = 1'b1; host_addr = 32'h0000_0200; settle();
    chk("t6_gnt", host_gnt, 1);
    next_cycle(); host_req = 1'b0; settle();
    next_cycle(); settle();
    chk("t6_cyc_before", wb_cyc, 1);
    rst = 1'b1; #1;
    chk("t6_cyc_async", wb_cyc, 0);
    chk("t6_stb_async", wb_stb, 0);
    chk("t6_rvalid_async", host_rvalid, 0);
    next_cycle(); wb_ack = 1'b1; wb_rdata = 32'hBAD0_BAD0; settle();
    next_cycle(); rst = 1'b0; wb_ack = 1'b0; wb_rdata = '0; settle();
    chk("t6_rvalid_in_rst", host_rvalid, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); settle();
      chk("t6_no_rvalid", host_rvalid, 0);
      chk("t6_idle_cyc", wb_cyc, 0);
    end
    next_cycle(); host_req = 1'b1; host_addr = 32'h0000_0300; settle();
    chk("t6_new_gnt", host_gnt, 1);
    next_cycle(); host_req = 1'b0; settle();
    chk("t6_new_stb", wb_stb, 1);
    next_cycle(); wb_ack = 1'b1; wb_rdata = 32'h600D_F00D; settle();
    next_cycle(); wb_ack = 1'b0; wb_rdata = '0; settle();
    chk("t6_new_rvalid", host_rvalid, 1);
    chk("t6_new_rdata", host_rdata, 32'h600D_F00D);
    chk("t6_new_err", host_err, 0);
    $display("txn 6 reset mid-wait done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
